// File: rtl/button_bank_pkg.sv
// Shared state encoding and default timing for the button_bank front end.
package button_bank_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_REL   = 2'd0;
    localparam state_t ST_CHK_P = 2'd1;
    localparam state_t ST_PRS   = 2'd2;
    localparam state_t ST_CHK_R = 2'd3;

    localparam int unsigned DEF_DB_CYCLES     = 1_000_000;
    localparam int unsigned DEF_LONG_CYCLES   = 100_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 20_000_000;

endpackage

// File: rtl/button_bank_chan.sv
// One button channel: synchroniser, debounce FSM, hold counter and tick outputs.
// Auto-repeat of press_tick is built only when BUTTON_BANK_REPEAT_EN is defined.
module button_chan
    import button_bank_pkg::*;
#(
    parameter int unsigned DB_W          = 20,
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned HOLD_W        = 32,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press_tick,
    output logic release_tick,
    output logic long_tick
);

    localparam logic [DB_W-1:0]   DB_LIM   = DB_W'(DB_CYCLES);
    localparam logic [HOLD_W-1:0] LONG_LIM = HOLD_W'(LONG_CYCLES);

    logic              sync_p0, sync_p1;
    state_t            state, state_nxt;
    logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
    logic [HOLD_W-1:0] hold;
    logic              db_done, accept_p, accept_r, in_hold, long_fire, rep_fire;

    // synchroniser: both flops start released
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_REL;
            db_cnt <= '0;
        end else begin
            state  <= state_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    assign db_done = (db_cnt == DB_LIM);

    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = '0;
        case (state)
            ST_REL: if (sync_p1) begin
                state_nxt  = ST_CHK_P;
                db_cnt_nxt = DB_W'(1);
            end
            ST_CHK_P: begin
                if (db_done)      state_nxt  = ST_PRS;
                else if (sync_p1) db_cnt_nxt = db_cnt + DB_W'(1);
                else              state_nxt  = ST_REL;
            end
            ST_PRS: if (!sync_p1) begin
                state_nxt  = ST_CHK_R;
                db_cnt_nxt = DB_W'(1);
            end
            default: begin
                if (db_done)       state_nxt  = ST_REL;
                else if (!sync_p1) db_cnt_nxt = db_cnt + DB_W'(1);
                else               state_nxt  = ST_PRS;
            end
        endcase
    end

    always_comb begin
        accept_p  = (state == ST_CHK_P) && db_done;
        accept_r  = (state == ST_CHK_R) && db_done;
        in_hold   = (state == ST_PRS) || (state == ST_CHK_R);
        long_fire = in_hold && ((hold + HOLD_W'(1)) == LONG_LIM);
    end

    // hold count survives a CHK_R bounce and saturates at all-ones
    always_ff @(posedge clk) begin
        if (rst)                    hold <= '0;
        else if (accept_p)          hold <= '0;
        else if (in_hold && !(&hold)) hold <= hold + HOLD_W'(1);
    end

`ifdef BUTTON_BANK_REPEAT_EN
    localparam logic [HOLD_W-1:0] REP_LIM = HOLD_W'(REPEAT_CYCLES);

    logic [HOLD_W-1:0] rep;
    logic              long_done;

    assign long_done = (hold >= LONG_LIM);
    assign rep_fire  = in_hold && long_done && ((rep + HOLD_W'(1)) == REP_LIM);

    always_ff @(posedge clk) begin
        if (rst)                       rep <= '0;
        else if (accept_p)             rep <= '0;
        else if (in_hold && long_done) rep <= rep_fire ? '0 : rep + HOLD_W'(1);
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level        <= 1'b0;
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            long_tick    <= 1'b0;
        end else begin
            level        <= in_hold;
            press_tick   <= accept_p | rep_fire;
            release_tick <= accept_r;
            long_tick    <= long_fire;
        end
    end

endmodule

// File: rtl/button_bank.sv
// Multi-channel push-button front end: polarity, per-channel debounce and press counters.
// Optional auto-repeat: define BUTTON_BANK_REPEAT_EN.
module button_bank
    import button_bank_pkg::*;
#(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned DB_W          = 20,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned HOLD_W        = 32,
    parameter int unsigned CNT_W         = 4,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_BTN-1:0]       button,
    input  logic [N_BTN-1:0]       cnt_clr,
    output logic [N_BTN-1:0]       level,
    output logic [N_BTN-1:0]       press_tick,
    output logic [N_BTN-1:0]       release_tick,
    output logic [N_BTN-1:0]       long_tick,
    output logic [N_BTN*CNT_W-1:0] cnt
);

    logic [N_BTN-1:0] pin;

    assign pin = button ^ {N_BTN{ACTIVE_LOW}};

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic [CNT_W-1:0] press_cnt;

        button_chan #(
            .DB_W          (DB_W),
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_W        (HOLD_W),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .pin          (pin[i]),
            .level        (level[i]),
            .press_tick   (press_tick[i]),
            .release_tick (release_tick[i]),
            .long_tick    (long_tick[i])
        );

        // clear wins over a coincident press
        always_ff @(posedge clk) begin
            if (rst)                press_cnt <= '0;
            else if (cnt_clr[i])    press_cnt <= '0;
            else if (press_tick[i]) press_cnt <= press_cnt + CNT_W'(1);
        end

        assign cnt[i*CNT_W +: CNT_W] = press_cnt;
    end

endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank: active-high and active-low instances against a run-length reference model.
module tb_button_bank;

    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int LONG = 16;
    localparam int REP  = 8;
    localparam int CW   = 4;
    localparam longint HOLD_MAX = 64'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     button = '0;
    logic [N-1:0]     button_n;
    logic [N-1:0]     cnt_clr = '0;
    logic [N-1:0]     level_a, press_a, release_a, long_a;
    logic [N-1:0]     level_b, press_b, release_b, long_b;
    logic [N*CW-1:0]  cnt_a, cnt_b;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // reference model state
    bit           h1[N], h2[N], acc[N];
    int           run[N];
    longint       hold[N], rep[N];
    int           cnt_m[N];
    logic [N-1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0;

    assign button_n = ~button;

    always #5 clk = ~clk;

    button_bank #(
        .N_BTN(N), .DB_CYCLES(DB), .DB_W(20), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP), .HOLD_W(32), .CNT_W(CW), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .button(button), .cnt_clr(cnt_clr),
        .level(level_a), .press_tick(press_a), .release_tick(release_a),
        .long_tick(long_a), .cnt(cnt_a)
    );

    button_bank #(
        .N_BTN(N), .DB_CYCLES(DB), .DB_W(20), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP), .HOLD_W(32), .CNT_W(CW), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .button(button_n), .cnt_clr(cnt_clr),
        .level(level_b), .press_tick(press_b), .release_tick(release_b),
        .long_tick(long_b), .cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the reference: sync value is the pin seen two edges earlier,
    // run counts consecutive samples that disagree with the accepted level.
    task automatic model_edge(input logic r, input logic [N-1:0] pins, input logic [N-1:0] clr);
        logic [N-1:0] np, nr, nl, nlv;
        np = '0; nr = '0; nl = '0; nlv = '0;
        if (r) begin
            for (int ch = 0; ch < N; ch++) begin
                h1[ch] = 0; h2[ch] = 0; acc[ch] = 0;
                run[ch] = 0; hold[ch] = 0; rep[ch] = 0; cnt_m[ch] = 0;
            end
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                bit s;
                s = h2[ch];
                h2[ch] = h1[ch];
                h1[ch] = pins[ch];
                if (clr[ch])          cnt_m[ch] = 0;
                else if (e_press[ch]) cnt_m[ch] = (cnt_m[ch] + 1) % (1 << CW);
                nlv[ch] = acc[ch];
                if (acc[ch]) begin
                    if (hold[ch] + 1 == LONG) nl[ch] = 1'b1;
`ifdef BUTTON_BANK_REPEAT_EN
                    if (hold[ch] >= LONG) begin
                        rep[ch]++;
                        if (rep[ch] == REP) begin
                            np[ch] = 1'b1;
                            rep[ch] = 0;
                        end
                    end
`endif
                    if (hold[ch] < HOLD_MAX) hold[ch]++;
                end
                if (run[ch] == DB) begin
                    acc[ch] = !acc[ch];
                    run[ch] = 0;
                    if (acc[ch]) begin
                        np[ch] = 1'b1;
                        hold[ch] = 0;
                        rep[ch] = 0;
                    end else begin
                        nr[ch] = 1'b1;
                    end
                end else if (s != acc[ch]) begin
                    run[ch]++;
                end else begin
                    run[ch] = 0;
                end
            end
        end
        e_level = nlv; e_press = np; e_release = nr; e_long = nl;
    endtask

    task automatic check_all();
        logic [N*CW-1:0] e_cnt;
        for (int ch = 0; ch < N; ch++) e_cnt[ch*CW +: CW] = CW'(cnt_m[ch]);
        check("level_hi", 32'(level_a), 32'(e_level));
        check("press_hi", 32'(press_a), 32'(e_press));
        check("release_hi", 32'(release_a), 32'(e_release));
        check("long_hi", 32'(long_a), 32'(e_long));
        check("cnt_hi", 32'(cnt_a), 32'(e_cnt));
        check("level_lo", 32'(level_b), 32'(e_level));
        check("press_lo", 32'(press_b), 32'(e_press));
        check("release_lo", 32'(release_b), 32'(e_release));
        check("long_lo", 32'(long_b), 32'(e_long));
        check("cnt_lo", 32'(cnt_b), 32'(e_cnt));
    endtask

    task automatic step();
        logic r;
        logic [N-1:0] p, c;
        r = rst; p = button; c = cnt_clr;
        @(posedge clk);
        model_edge(r, p, c);
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int dur[N];
        bit hit;

        // reset
        rst = 1'b1;
        steps(3);
        check("rst_outputs", 32'({level_a, press_a, release_a, long_a}), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        steps(5);

        // clean press on ch0
        button[0] = 1'b1;
        steps(20);
        button[0] = 1'b0;
        steps(12);
        check("clean_cnt0", 32'(cnt_a[3:0]), 32'd1);

        // bounce on ch1, shorter than the debounce window
        for (int k = 0; k < 10; k++) begin
            button[1] = ~button[1];
            steps(2);
        end
        button[1] = 1'b0;
        steps(10);
        check("bounce_cnt1", 32'(cnt_a[7:4]), 32'd0);
        check("bounce_level1", 32'(level_a[1]), 32'd0);

        // long press on ch2: pressed span of 35 cycles after press_tick
        button[2] = 1'b1;
        steps(35);
        button[2] = 1'b0;
        steps(12);
`ifdef BUTTON_BANK_REPEAT_EN
        check("long_cnt2", 32'(cnt_a[11:8]), 32'd3);
`else
        check("long_cnt2", 32'(cnt_a[11:8]), 32'd1);
`endif

        // 17 presses on ch3 wrap the 4-bit counter to 1
        for (int k = 0; k < 17; k++) begin
            button[3] = 1'b1;
            steps(8);
            button[3] = 1'b0;
            steps(8);
        end
        check("wrap_cnt3", 32'(cnt_a[15:12]), 32'd1);

        // clear coinciding with a press_tick
        button[3] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            step();
            if (press_a[3]) begin
                cnt_clr[3] = 1'b1;
                step();
                cnt_clr[3] = 1'b0;
                hit = 1'b1;
            end
        end
        check("clr_press_seen", 32'(hit), 32'd1);
        check("clr_cnt3", 32'(cnt_a[15:12]), 32'd0);
        button[3] = 1'b0;
        steps(12);

        // reset during ch2 hold and ch0 debounce, both held across it
        button[2] = 1'b1;
        steps(12);
        button[0] = 1'b1;
        steps(3);
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        steps(40);
        button[0] = 1'b0;
        button[2] = 1'b0;
        steps(12);

        // randomized pin activity, occasional clears and resets
        for (int ch = 0; ch < N; ch++) dur[ch] = 1;
        repeat (800) begin
            for (int ch = 0; ch < N; ch++) begin
                dur[ch]--;
                if (dur[ch] == 0) begin
                    button[ch] = ~button[ch];
                    dur[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                          : int'($urandom_range(1, 12));
                end
            end
            cnt_clr = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        cnt_clr = '0;
        button = '0;
        steps(15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
